// File: rtl/fsm_pkg.sv
// Shared encodings for the sequencer-facing data collector: sequencer state
// codes, FIFO entry tags and the collector's own FSM states.
package fsm_pkg;

    localparam logic [3:0] S1 = 4'b0000;
    localparam logic [3:0] S2 = 4'b0001;
    localparam logic [3:0] S3 = 4'b0010;
    localparam logic [3:0] S4 = 4'b0100;

    localparam logic [1:0] TAG_NONE = 2'b00;
    localparam logic [1:0] TAG_D1   = 2'b01;
    localparam logic [1:0] TAG_D2   = 2'b10;
    localparam logic [1:0] TAG_MARK = 2'b11;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CAPT       = 2'd1,
        MARK       = 2'd2,
        WAIT_DRAIN = 2'd3
    } coll_state_t;

    typedef enum logic [1:0] {
        SEQ_S1,
        SEQ_S2,
        SEQ_S3,
        SEQ_S4
    } seq_state_t;

    // Unknown sequencer codes fall back to S1 so a glitchy code aborts a frame.
    function automatic seq_state_t decode_state(input logic [3:0] code);
        case (code)
            S2:      return SEQ_S2;
            S3:      return SEQ_S3;
            S4:      return SEQ_S4;
            default: return SEQ_S1;
        endcase
    endfunction

endpackage

// File: rtl/fsm_sync_fifo.sv
// Single-clock show-ahead FIFO with wrap-bit pointers; a push into a full
// FIFO is accepted only when a pop frees the head slot on the same edge.
module fsm_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         push_ok,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    // Head reads as zero when empty so stale storage never leaks out.
    assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/fsm_data_collector.sv
// Collects STATE2/STATE3 samples from the sequencer into a FIFO, appends an
// end-of-frame marker and pulses drain-done. FSM_COLLECT_PARITY_EN adds parity.
module fsm_data_collector
    import fsm_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    i_state,
    input  logic [DW-1:0] i_data1,
    input  logic [DW-1:0] i_data2,
    input  logic          i_cap_en,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [1:0]    o_tag,
    output logic [DW-1:0] o_data,
    output logic          o_parity,
    output logic          o_full,
    output logic          o_empty,
    output logic [7:0]    o_ovf_cnt,
    output logic          o_drain_done,
    output logic [1:0]    o_dbg_state
);

`ifdef FSM_COLLECT_PARITY_EN
    localparam int EW = DW + 3;
`else
    localparam int EW = DW + 2;
`endif

    seq_state_t    seq;
    coll_state_t   state;
    coll_state_t   state_nxt;
    logic          frame_start;
    logic          push_req;
    logic [1:0]    push_tag;
    logic [DW-1:0] push_data;
    logic [EW-1:0] push_entry;
    logic [EW-1:0] head_entry;
    logic          push_ok;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic          drain_req;
    logic          drain_q;
    logic [7:0]    sample_cnt;
    logic [7:0]    ovf_cnt;

    assign seq         = decode_state(i_state);
    // The first S2 cycle is captured even though the FSM still reads IDLE.
    assign frame_start = (state == IDLE) && (seq == SEQ_S2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (seq == SEQ_S2) state_nxt = CAPT;
            CAPT:       if (seq == SEQ_S4) state_nxt = MARK;
            MARK:       state_nxt = WAIT_DRAIN;
            WAIT_DRAIN: if (drain_req) state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
        if (seq == SEQ_S1) state_nxt = IDLE;
    end

    always_comb begin
        push_req  = 1'b0;
        push_tag  = TAG_NONE;
        push_data = '0;
        if ((state == CAPT || frame_start) && i_cap_en) begin
            if (seq == SEQ_S2) begin
                push_req  = 1'b1;
                push_tag  = TAG_D1;
                push_data = i_data1;
            end else if (seq == SEQ_S3) begin
                push_req  = 1'b1;
                push_tag  = TAG_D2;
                push_data = i_data2;
            end
        end else if (state == MARK) begin
            push_req  = 1'b1;
            push_tag  = TAG_MARK;
            push_data = DW'(sample_cnt);
        end
    end

`ifdef FSM_COLLECT_PARITY_EN
    assign push_entry = {^{push_tag, push_data}, push_tag, push_data};
    assign o_parity   = head_entry[EW-1];
`else
    assign push_entry = {push_tag, push_data};
    assign o_parity   = 1'b0;
`endif

    assign pop = o_valid && i_ready;

    fsm_sync_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_req),
        .push_data (push_entry),
        .pop       (pop),
        .push_ok   (push_ok),
        .head      (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign drain_req = (state == WAIT_DRAIN) && (seq == SEQ_S4) && fifo_empty && !push_req;

    // Counters restart with the frame, keeping the first cycle's own push/drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt <= '0;
            ovf_cnt    <= '0;
            drain_q    <= 1'b0;
        end else begin
            drain_q <= drain_req;
            if (frame_start) begin
                sample_cnt <= push_ok ? 8'd1 : 8'd0;
                ovf_cnt    <= (push_req && !push_ok) ? 8'd1 : 8'd0;
            end else begin
                if (push_ok && push_tag != TAG_MARK && sample_cnt != 8'hFF)
                    sample_cnt <= sample_cnt + 8'd1;
                if (push_req && !push_ok && ovf_cnt != 8'hFF)
                    ovf_cnt <= ovf_cnt + 8'd1;
            end
        end
    end

    assign o_valid      = !fifo_empty;
    assign o_tag        = head_entry[DW+1:DW];
    assign o_data       = head_entry[DW-1:0];
    assign o_full       = fifo_full;
    assign o_empty      = fifo_empty;
    assign o_ovf_cnt    = ovf_cnt;
    assign o_drain_done = drain_q;
    assign o_dbg_state  = state;

endmodule

// File: doc/fsm_data_collector.md
Name: fsm_data_collector

Overview:
- Downstream consumer of the four-state sequencer (STATE1..STATE4). Samples the sequencer's state code and its two data outputs every cycle.
- Buffers STATE2 samples (data1) and STATE3 samples (data2) in a small FIFO, then appends one end-of-frame marker. Results are presented on a valid/ready stream.
- Generates the drain-complete pulse that drives the sequencer's STATE4->STATE1 return input.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, minimum 2.
- DW, 8, data width; matches the sequencer's o_data1/o_data2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset; one clock domain only
- i_state  in  4  sequencer state code
- i_data1  in  DW  sequencer data1 (0-9 or 10-19 in STATE2, else 0)
- i_data2  in  DW  sequencer data2 (0-20 in STATE3, else 0)
- i_cap_en  in  1  capture enable
- o_valid  out  1  output entry valid
- i_ready  in  1  sink accepts the entry
- o_tag  out  2  entry type: 01 data1, 10 data2, 11 marker, 00 none
- o_data  out  DW  entry payload
- o_parity  out  1  even parity over {o_tag,o_data} (optional feature)
- o_full  out  1  FIFO full
- o_empty  out  1  FIFO empty
- o_ovf_cnt  out  8  dropped-push count, saturates at 255
- o_drain_done  out  1  one-cycle pulse, wired to the sequencer's state4_to_state1

Behaviour:
- State codes: S1=4'b0000, S2=4'b0001, S3=4'b0010, S4=4'b0100. Any other code is treated as S1.
- Reset values:
  - o_valid=0, o_tag=0, o_data=0, o_parity=0, o_full=0, o_empty=1, o_ovf_cnt=0, o_drain_done=0.
  - FIFO pointers 0; internal FSM in IDLE; sample count 0.
- Internal FSM, registered:
  - IDLE->CAPT when i_state==S2.
  - CAPT->MARK when i_state==S4.
  - MARK->WAIT_DRAIN after exactly one cycle.
  - WAIT_DRAIN->IDLE when o_drain_done fires, or when i_state==S1.
  - In any state, i_state==S1 returns the FSM to IDLE next cycle.
- Push requests:
  - CAPT with i_cap_en=1 and i_state==S2 pushes {01,i_data1}.
  - CAPT with i_cap_en=1 and i_state==S3 pushes {10,i_data2}.
  - MARK pushes {11,sample count}. The marker is pushed regardless of i_cap_en.
- Sample count:
  - Counts accepted data pushes in the current frame, saturating at 255.
  - Cleared on the IDLE->CAPT transition.
- Pop: o_valid & i_ready. FIFO is show-ahead: o_tag/o_data reflect the head entry while o_valid=1, and are 0 when empty.
- Latency: a push at edge N into an empty FIFO gives o_valid=1 after edge N. Push-to-output latency is 1 cycle.
- Full:
  - A push is accepted if !o_full, or if a pop occurs in the same cycle.
  - Otherwise the push is dropped and o_ovf_cnt increments, saturating at 255.
  - o_ovf_cnt is cleared on IDLE->CAPT.
- Empty: a pop cannot occur (o_valid=0). Simultaneous push and pop on an empty FIFO is impossible; the push lands normally.
- Pointers: log2(DEPTH)+1 bits and wrap naturally. Full = MSBs differ and LSBs equal; empty = pointers equal.
- o_drain_done: registered single-cycle pulse when FSM==WAIT_DRAIN, i_state==S4 and FIFO empty with no push pending. After the pulse the FSM leaves WAIT_DRAIN, so the pulse never repeats.
- Held i_ready=0 stalls the output indefinitely. o_tag/o_data are stable while o_valid=1 and i_ready=0.
- rst asserted mid-frame: FIFO contents are discarded immediately (pointers reset) and all outputs return to their reset values asynchronously.

Optional Feature:
- Macro FSM_COLLECT_PARITY_EN.
- Defined: each FIFO entry stores an extra parity bit computed at push; o_parity = stored even parity of {tag,data} for the head entry, 0 when empty.
- Undefined: no parity storage; o_parity tied 0.

Decomposition:
- Package fsm_pkg:
  - state codes S1..S4
  - tag codes TAG_NONE/TAG_D1/TAG_D2/TAG_MARK
  - collector FSM encoding IDLE/CAPT/MARK/WAIT_DRAIN
- Sub-module fsm_sync_fifo (DEPTH, width parameters; push/pop/full/empty, show-ahead read).
- The collector holds the FSM, push arbitration, counters and drain logic.

Test Plan:
- Frame capture: S1 3 cycles, S2 10 cycles (data1 0..9), S3 21 cycles (data2 0..20), S4, i_cap_en=1, i_ready=1 -> 31 data entries in order, then marker {11,31}; o_drain_done pulses once with FIFO empty.
- Back-pressure: same frame, DEPTH=8, i_ready=0 throughout -> 8 entries held, o_full=1, o_ovf_cnt=24 (23 data + marker dropped); o_drain_done only after i_ready=1 drains to empty.
- Push and pop when full: full FIFO, i_ready=1 with an S3 push in the same cycle -> push accepted, o_full stays 1, o_ovf_cnt unchanged.
- Capture gating: i_cap_en=0 through S2/S3 -> only the marker {11,0} is emitted.
- Reset mid-frame: rst pulse in S3 with 5 entries queued -> o_valid=0, o_empty=1, o_ovf_cnt=0 immediately; the next frame starts clean.
- Parity (FSM_COLLECT_PARITY_EN): entry {10,8'd7} -> o_parity=0; {01,8'd10} -> o_parity=1; undefined macro -> o_parity=0 always.
